// File: rtl/event_pulse_arbiter.sv
// Event pulse arbiter: synchronizes, debounces and edge-detects two raw event lines.
// Buffers the detected events per channel and issues them one at a time as En/Slt pulses.
module event_pulse_arbiter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PEND_W          = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              raw0_i,
    input  logic              raw1_i,
    input  logic              hold_i,
    input  logic              clr_ovf_i,
    output logic              en_o,
    output logic              slt_o,
    output logic [PEND_W-1:0] pend0_o,
    output logic [PEND_W-1:0] pend1_o,
    output logic              ovf_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax = '1;

    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][CntW-1:0]        db_cnt_q, db_cnt_d;
    logic [1:0]                  db_lvl_q, db_lvl_d;
    logic [1:0]                  db_prev_q;
    logic [1:0][PEND_W-1:0]      pend_q, pend_d;
    logic                        rr_q, rr_d;
    logic                        en_q, en_d;
    logic                        slt_q, slt_d;
    logic                        ovf_q, ovf_d;

    logic [1:0] raw;
    logic [1:0] synced;
    logic [1:0] ev;
    logic [1:0] grant;
    logic [1:0] drop;

    assign raw = {raw1_i, raw0_i};

    always_comb begin
        sync_d   = sync_q;
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        synced   = '0;
        for (int c = 0; c < 2; c++) begin
            sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], raw[c]};
            synced[c] = sync_q[c][SYNC_STAGES-1];
            if (synced[c] != db_lvl_q[c]) begin
                // Reaching the threshold toggles the level instead of storing the count.
                if (db_cnt_q[c] == DebLast) begin
                    db_lvl_d[c] = ~db_lvl_q[c];
                    db_cnt_d[c] = '0;
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + CntW'(1);
                end
            end else begin
                db_cnt_d[c] = '0;
            end
        end
    end

    assign ev = db_lvl_q & ~db_prev_q;

    always_comb begin
        grant = 2'b00;
        if (!hold_i) begin
            case ({|pend_q[1], |pend_q[0]})
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
        en_d  = |grant;
        slt_d = (|grant) ? grant[1] : slt_q;
        rr_d  = rr_q ^ (|grant);
    end

    always_comb begin
        pend_d = pend_q;
        drop   = '0;
        for (int c = 0; c < 2; c++) begin
            if (ev[c] && !grant[c]) begin
                if (pend_q[c] == PendMax) begin
                    drop[c] = 1'b1;
                end else begin
                    pend_d[c] = pend_q[c] + PEND_W'(1);
                end
            end else if (grant[c] && !ev[c]) begin
                pend_d[c] = pend_q[c] - PEND_W'(1);
            end
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (|drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            db_lvl_q  <= '0;
            db_prev_q <= '0;
            pend_q    <= '0;
            rr_q      <= 1'b0;
            en_q      <= 1'b0;
            slt_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            pend_q    <= pend_d;
            rr_q      <= rr_d;
            en_q      <= en_d;
            slt_q     <= slt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign en_o    = en_q;
    assign slt_o   = slt_q;
    assign pend0_o = pend_q[0];
    assign pend1_o = pend_q[1];
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_event_pulse_arbiter.sv
// Bench for event_pulse_arbiter: directed scenarios plus random raw/hold/clear traffic,
// with a cycle-level reference model feeding an issue scoreboard.
module tb_event_pulse_arbiter;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          raw0 = 1'b0;
    logic          raw1 = 1'b0;
    logic          hold = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          en;
    logic          slt;
    logic [PW-1:0] pend0;
    logic [PW-1:0] pend1;
    logic          ovf;

    int vectors = 0;
    int miscompares = 0;

    event_pulse_arbiter #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .PEND_W         (PW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .raw0_i   (raw0),
        .raw1_i   (raw1),
        .hold_i   (hold),
        .clr_ovf_i(clr_ovf),
        .en_o     (en),
        .slt_o    (slt),
        .pend0_o  (pend0),
        .pend1_o  (pend1),
        .ovf_o    (ovf)
    );

    always #5 clk = ~clk;

    // Reference model state: raw history, filtered level, event counts, issue order.
    bit m_hist [2][SYNC] = '{default: 1'b0};
    bit m_lvl  [2] = '{default: 1'b0};
    bit m_lvlp [2] = '{default: 1'b0};
    int m_run  [2] = '{default: 0};
    int m_pend [2] = '{default: 0};
    bit m_ovf = 1'b0;
    bit m_ptr = 1'b0;
    bit exp_q [$];

    bit mr_ev [2];
    bit mr_raw [2];
    int mr_g;
    bit mr_drop;

    task automatic cmp(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < SYNC; i++) m_hist[c][i] = 1'b0;
                m_lvl[c] = 1'b0; m_lvlp[c] = 1'b0; m_run[c] = 0; m_pend[c] = 0;
            end
            m_ovf = 1'b0;
            m_ptr = 1'b0;
            exp_q.delete();
        end else begin
            mr_raw[0] = raw0;
            mr_raw[1] = raw1;
            for (int c = 0; c < 2; c++) mr_ev[c] = m_lvl[c] && !m_lvlp[c];
            // Who gets served this cycle (-1 = nobody).
            mr_g = -1;
            if (!hold) begin
                if (m_pend[0] > 0 && m_pend[1] > 0) mr_g = m_ptr;
                else if (m_pend[0] > 0) mr_g = 0;
                else if (m_pend[1] > 0) mr_g = 1;
            end
            if (mr_g >= 0) begin
                exp_q.push_back(mr_g[0]);
                m_ptr = !m_ptr;
            end
            mr_drop = 1'b0;
            for (int c = 0; c < 2; c++) begin
                int delta;
                delta = (mr_ev[c] ? 1 : 0) - ((mr_g == c) ? 1 : 0);
                if (m_pend[c] + delta > PMAX) mr_drop = 1'b1;
                else m_pend[c] = m_pend[c] + delta;
            end
            if (mr_drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            for (int c = 0; c < 2; c++) begin
                bit seen;
                seen = m_hist[c][SYNC-1];
                m_lvlp[c] = m_lvl[c];
                if (seen != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_lvl[c] = seen;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                for (int i = SYNC - 1; i > 0; i--) m_hist[c][i] = m_hist[c][i-1];
                m_hist[c][0] = mr_raw[c];
            end
        end
    end

    // Monitor: every issue strobe must match the next expected grant.
    always @(negedge clk) begin
        cmp("pend0", int'(pend0), m_pend[0]);
        cmp("pend1", int'(pend1), m_pend[1]);
        cmp("ovf", int'(ovf), int'(m_ovf));
        if (en) begin
            if (exp_q.size() == 0) begin
                cmp("en_unexpected", 1, 0);
            end else begin
                bit s;
                s = exp_q.pop_front();
                cmp("slt", int'(slt), int'(s));
            end
        end else if (exp_q.size() != 0) begin
            cmp("en_missing", 0, 1);
            exp_q.delete();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; raw0 = 1'b0; raw1 = 1'b0; hold = 1'b0; clr_ovf = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulses(input bit c0, input bit c1, input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            raw0 = c0; raw1 = c1;
            tick(hi);
            raw0 = 1'b0; raw1 = 1'b0;
            tick(lo);
        end
    endtask

    // Returns at the negedge just before the edge on which a ch0 event gets counted.
    task automatic wait_ev0_next();
        int n;
        n = 0;
        while (!(m_lvl[0] && !m_lvlp[0]) && n < 40) begin
            tick(1);
            n++;
        end
        if (n >= 40) cmp("ev0_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        tick(1);
        cmp("reset_en", int'(en), 0);
        cmp("reset_pend0", int'(pend0), 0);
        do_reset();

        // 1: latency from raw edge to issue strobe.
        raw0 = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (en) break;
        end
        cmp("latency", lat, 8);
        cmp("latency_slt", int'(slt), 0);
        tick(2);
        raw0 = 1'b0;
        tick(15);

        // 2: short pulse filtered, long pulse passes.
        pulses(1'b0, 1'b1, 1, 3, 12);
        cmp("short_pend1", int'(pend1), 0);
        pulses(1'b0, 1'b1, 1, 5, 12);

        // 3: buffered events on both channels drain alternately.
        do_reset();
        hold = 1'b1;
        pulses(1'b1, 1'b1, 3, 6, 6);
        tick(8);
        cmp("held_pend0", int'(pend0), 3);
        cmp("held_pend1", int'(pend1), 3);
        hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            cmp("rr_en", int'(en), 1);
            cmp("rr_slt", int'(slt), i % 2);
        end
        tick(1);
        cmp("rr_done_en", int'(en), 0);
        cmp("rr_done_pend0", int'(pend0), 0);

        // 4: saturation, overflow, clear, and drop beating clear.
        do_reset();
        hold = 1'b1;
        pulses(1'b1, 1'b0, 16, 6, 6);
        tick(8);
        cmp("sat_pend0", int'(pend0), PMAX);
        cmp("sat_ovf", int'(ovf), 1);
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        cmp("clr_ovf", int'(ovf), 0);
        raw0 = 1'b1;
        wait_ev0_next();
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        cmp("drop_wins", int'(ovf), 1);
        raw0 = 1'b0;
        tick(8);

        // 5: event coinciding with a grant at full count.
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        raw0 = 1'b1;
        wait_ev0_next();
        hold = 1'b0;
        tick(1);
        cmp("coinc_en", int'(en), 1);
        cmp("coinc_slt", int'(slt), 0);
        cmp("coinc_pend0", int'(pend0), PMAX);
        cmp("coinc_ovf", int'(ovf), 0);
        raw0 = 1'b0;
        tick(25);

        // 6: asynchronous reset mid-operation.
        do_reset();
        hold = 1'b1;
        pulses(1'b1, 1'b0, 5, 6, 6);
        tick(8);
        cmp("pre_rst_pend0", int'(pend0), 5);
        hold = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_en", int'(en), 0);
        cmp("async_pend0", int'(pend0), 0);
        cmp("async_ovf", int'(ovf), 0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        cmp("post_rst_pend0", int'(pend0), 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) raw0 = ~raw0;
            if ($urandom_range(0, 7) == 0) raw1 = ~raw1;
            if ($urandom_range(0, 149) == 0) hold = ~hold;
            clr_ovf = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        raw0 = 1'b0; raw1 = 1'b0; hold = 1'b0; clr_ovf = 1'b0;
        tick(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
